// File: rtl/fbreader_pkg.sv
// Shared definitions for the framebuffer scan-out master: region base address,
// address field widths, default frame geometry, PLB widths and FSM encoding.
// The state encoding matches fbwriter so the two can be debugged side by side.
package fbreader_pkg;

  localparam logic [10:0]  FB_BASE_ADDR = 11'b1001_0000_000;
  localparam int unsigned  LINE_LEN     = 9;
  localparam int unsigned  COL_LEN      = 10;
  localparam int unsigned  NUM_LINES    = 480;
  localparam int unsigned  NUM_COLS     = 640;
  localparam int unsigned  C_MST_AWIDTH = 32;
  localparam int unsigned  C_MST_DWIDTH = 32;
  localparam int unsigned  C_MST_BEWIDTH = C_MST_DWIDTH / 8;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StReq   = 4'd1,
    StRetry = 4'd2,
    StData  = 4'd3,
    StPush  = 4'd4
  } state_e;

  // Word address of pixel (line, col) inside the framebuffer region.
  function automatic logic [C_MST_AWIDTH-1:0] pix_addr(input logic [LINE_LEN-1:0] line,
                                                       input logic [COL_LEN-1:0]  col);
    return {FB_BASE_ADDR, line, col, 2'b00};
  endfunction

endpackage

// File: rtl/fbreader_if.sv
// PLB master IPIF signal bundle.
//   master modport: used by fbreader (drives requests, receives status/data).
//   slave modport:  used by the bus side (IPIF or a bus model).
interface fbreader_if;
  import fbreader_pkg::*;

  logic                     IP2Bus_MstRd_Req;
  logic                     IP2Bus_MstWr_Req;
  logic [C_MST_AWIDTH-1:0]  IP2Bus_Mst_Addr;
  logic [C_MST_BEWIDTH-1:0] IP2Bus_Mst_BE;
  logic                     IP2Bus_Mst_Lock;
  logic                     IP2Bus_Mst_Reset;
  logic [C_MST_DWIDTH-1:0]  IP2Bus_MstWr_d;

  logic                     Bus2IP_Mst_CmdAck;
  logic                     Bus2IP_Mst_Cmplt;
  logic                     Bus2IP_Mst_Error;
  logic                     Bus2IP_Mst_Rearbitrate;
  logic                     Bus2IP_Mst_Cmd_Timeout;
  logic [C_MST_DWIDTH-1:0]  Bus2IP_MstRd_d;
  logic                     Bus2IP_MstRd_src_rdy_n;
  logic                     Bus2IP_MstWr_dst_rdy_n;

  modport master (
    output IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
           IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
    input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_Mst_Rearbitrate,
           Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n,
           Bus2IP_MstWr_dst_rdy_n
  );

  modport slave (
    input  IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
           IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
    output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_Mst_Rearbitrate,
           Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n,
           Bus2IP_MstWr_dst_rdy_n
  );

endinterface

// File: rtl/fbreader_scan_counter.sv
// Raster scan position for fbreader.
//   PLB_clk, reset : clock, synchronous active-high reset
//   clear          : return to (0,0); wins over advance
//   advance        : step one pixel in raster order with line/col wrap
//   line, col      : current scan position
//   frame_done     : advance of the last pixel of the frame
module fbreader_scan_counter
  import fbreader_pkg::*;
#(
  parameter int unsigned NumLines = NUM_LINES,
  parameter int unsigned NumCols  = NUM_COLS
) (
  input  logic                PLB_clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                advance,
  output logic [LINE_LEN-1:0] line,
  output logic [COL_LEN-1:0]  col,
  output logic                frame_done
);

  localparam logic [LINE_LEN-1:0] LastLine = LINE_LEN'(NumLines - 1);
  localparam logic [COL_LEN-1:0]  LastCol  = COL_LEN'(NumCols - 1);

  logic [LINE_LEN-1:0] line_q, line_d;
  logic [COL_LEN-1:0]  col_q, col_d;
  logic                at_last;

  assign at_last    = (line_q == LastLine) && (col_q == LastCol);
  // Reported even if a restart clears the position on the same edge.
  assign frame_done = advance && at_last;
  assign line       = line_q;
  assign col        = col_q;

  always_comb begin
    line_d = line_q;
    col_d  = col_q;
    if (clear) begin
      line_d = '0;
      col_d  = '0;
    end else if (advance) begin
      if (col_q == LastCol) begin
        col_d  = '0;
        line_d = (line_q == LastLine) ? '0 : line_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge PLB_clk) begin
    if (reset) begin
      line_q <= '0;
      col_q  <= '0;
    end else begin
      line_q <= line_d;
      col_q  <= col_d;
    end
  end

endmodule

// File: rtl/fbreader.sv
// Framebuffer scan-out PLB master. Reads one pixel per single-beat command in
// raster order and writes it to the display-side FIFO.
//   PLB_clk, reset     : clock, synchronous active-high reset
//   enable             : keep scanning; low stops after the in-flight pixel
//   restart            : next request starts at (0,0)
//   pix_data/pix_wr_en : FIFO write data and one-cycle strobe
//   pix_fifo_full      : FIFO backpressure; stalls the pixel write
//   frame_done         : pulse with the write of the last pixel of a frame
//   err_count          : saturating count of errored or timed-out reads
//   state              : FSM state for debug visibility
//   plb                : PLB master IPIF signals
module fbreader
  import fbreader_pkg::*;
#(
  parameter int unsigned NumLines = NUM_LINES,
  parameter int unsigned NumCols  = NUM_COLS
) (
  input  logic                    PLB_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    restart,
  output logic [C_MST_DWIDTH-1:0] pix_data,
  output logic                    pix_wr_en,
  input  logic                    pix_fifo_full,
  output logic                    frame_done,
  output logic [15:0]             err_count,
  output logic [3:0]              state,
  fbreader_if.master              plb
);

  state_e                  state_q, state_d;
  logic [C_MST_DWIDTH-1:0] pixel_q, pixel_d;
  logic [15:0]             err_q, err_d;
  logic                    err_inc;
  logic                    restart_pend_q, restart_pend_d;
  logic                    restart_any;
  logic                    mst_reset_q;
  logic                    scan_clear;
  logic                    scan_advance;
  logic [LINE_LEN-1:0]     line;
  logic [COL_LEN-1:0]      col;
  logic                    unused_dst_rdy;

  fbreader_scan_counter #(
    .NumLines (NumLines),
    .NumCols  (NumCols)
  ) u_scan (
    .PLB_clk    (PLB_clk),
    .reset      (reset),
    .clear      (scan_clear),
    .advance    (scan_advance),
    .line       (line),
    .col        (col),
    .frame_done (frame_done)
  );

  // A restart seen mid-command is held until the position is free to move,
  // so the address of an outstanding command never changes under it.
  assign restart_any    = restart || restart_pend_q;
  assign scan_clear     = restart_any && ((state_q == StIdle) || pix_wr_en);
  assign restart_pend_d = restart_any && !scan_clear;

  always_comb begin
    state_d      = state_q;
    pixel_d      = pixel_q;
    err_inc      = 1'b0;
    pix_wr_en    = 1'b0;
    scan_advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && !pix_fifo_full) state_d = StReq;
      end
      StReq: begin
        if (plb.Bus2IP_Mst_CmdAck) begin
          state_d = StData;
        end else if (plb.Bus2IP_Mst_Rearbitrate) begin
          state_d = StRetry;
        end else if (plb.Bus2IP_Mst_Cmd_Timeout) begin
          pixel_d = '0;
          err_inc = 1'b1;
          state_d = StPush;
        end
      end
      StRetry: begin
        state_d = StReq;
      end
      StData: begin
        if (!plb.Bus2IP_MstRd_src_rdy_n) pixel_d = plb.Bus2IP_MstRd_d;
        if (plb.Bus2IP_Mst_Cmplt) begin
          state_d = StPush;
          // Error overrides any data latched in the same cycle.
          if (plb.Bus2IP_Mst_Error) begin
            pixel_d = '0;
            err_inc = 1'b1;
          end
        end
      end
      StPush: begin
        if (!pix_fifo_full) begin
          pix_wr_en    = 1'b1;
          scan_advance = 1'b1;
          state_d      = enable ? StReq : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign err_d = (err_inc && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;

  always_ff @(posedge PLB_clk) begin
    if (reset) begin
      state_q        <= StIdle;
      pixel_q        <= '0;
      err_q          <= '0;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pixel_q        <= pixel_d;
      err_q          <= err_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  always_ff @(posedge PLB_clk) begin
    mst_reset_q <= reset;
  end

  assign pix_data  = pixel_q;
  assign err_count = err_q;
  assign state     = state_q;

  // Position only moves in IDLE/PUSH, so the address is stable REQ..DATA.
  assign plb.IP2Bus_Mst_Addr  = (state_q inside {StReq, StRetry, StData}) ?
                                pix_addr(line, col) : '0;
  assign plb.IP2Bus_MstRd_Req = (state_q == StReq);
  assign plb.IP2Bus_MstWr_Req = 1'b0;
  assign plb.IP2Bus_Mst_BE    = '1;
  assign plb.IP2Bus_Mst_Lock  = 1'b0;
  assign plb.IP2Bus_Mst_Reset = mst_reset_q;
  assign plb.IP2Bus_MstWr_d   = '0;

  assign unused_dst_rdy = plb.Bus2IP_MstWr_dst_rdy_n;

endmodule

// File: tb/tb_fbreader.sv
module tb_fbreader;

  localparam int unsigned Lines = 2;
  localparam int unsigned Cols  = 4;
  localparam int unsigned Total = Lines * Cols;

  logic        PLB_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        restart;
  logic [31:0] pix_data;
  logic        pix_wr_en;
  logic        pix_fifo_full;
  logic        frame_done;
  logic [15:0] err_count;
  logic [3:0]  state;
  logic        full_force;
  logic        full_rand;
  logic        full_rand_en;

  fbreader_if plb ();

  fbreader #(
    .NumLines (Lines),
    .NumCols  (Cols)
  ) dut (
    .PLB_clk       (PLB_clk),
    .reset         (reset),
    .enable        (enable),
    .restart       (restart),
    .pix_data      (pix_data),
    .pix_wr_en     (pix_wr_en),
    .pix_fifo_full (pix_fifo_full),
    .frame_done    (frame_done),
    .err_count     (err_count),
    .state         (state),
    .plb           (plb)
  );

  always #5 PLB_clk = ~PLB_clk;

  assign pix_fifo_full = full_force | full_rand;

  always @(posedge PLB_clk) begin
    #1;
    full_rand <= full_rand_en && ($urandom_range(0, 3) == 0);
  end

  typedef struct {
    logic [31:0] data;
    logic        fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   idx      = 0;   // model scan position as a linear pixel index
  int   err_exp  = 0;
  bit   mon_en   = 0;

  // Address of the pixel at linear index i in a Lines x Cols frame.
  function automatic logic [31:0] exp_addr(input int i);
    return 32'h9000_0000 + 32'((i / Cols) << 12) + 32'((i % Cols) << 2);
  endfunction

  function automatic void push_exp(input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.fd   = (idx == Total - 1);
    exp_q.push_back(e);
    idx = (idx + 1) % Total;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge PLB_clk);
      if (mon_en && !reset) begin
        if (pix_wr_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got data %h expected no write", pix_data);
          end else begin
            e = exp_q.pop_front();
            chk("pix_data", pix_data, e.data);
            chk("frame_done", 32'(frame_done), 32'(e.fd));
          end
        end else if (frame_done) begin
          chk("stray_frame_done", 32'(frame_done), 32'd0);
        end
        if (pix_fifo_full) chk("stall_wr_en", 32'(pix_wr_en), 32'd0);
      end
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge PLB_clk);
      if (plb.IP2Bus_MstRd_Req) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: got no Req expected Req within 200 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge PLB_clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // kind: 0 good read, 1 Error with Cmplt, 2 Cmd_Timeout, 3 Rearbitrate then good read
  task automatic serve(input int kind, input logic [31:0] d, input int ack_lat,
                       input int dat_lat, input bit same_cycle, input bit stall);
    logic [31:0] a;
    bit          ok;
    wait_req(ok);
    if (!ok) return;
    a = exp_addr(idx);
    chk("req_addr", plb.IP2Bus_Mst_Addr, a);
    if (kind == 3) begin
      @(posedge PLB_clk); #1;
      plb.Bus2IP_Mst_Rearbitrate = 1'b1;
      @(posedge PLB_clk); #1;
      plb.Bus2IP_Mst_Rearbitrate = 1'b0;
      @(negedge PLB_clk);
      chk("retry_req_low", 32'(plb.IP2Bus_MstRd_Req), 32'd0);
      @(negedge PLB_clk);
      chk("retry_req_high", 32'(plb.IP2Bus_MstRd_Req), 32'd1);
      chk("retry_addr", plb.IP2Bus_Mst_Addr, a);
    end
    repeat (ack_lat - 1) @(negedge PLB_clk);
    @(posedge PLB_clk); #1;
    if (kind == 2) begin
      plb.Bus2IP_Mst_Cmd_Timeout = 1'b1;
      if (stall) full_force = 1'b1;
    end else begin
      plb.Bus2IP_Mst_CmdAck = 1'b1;
    end
    @(posedge PLB_clk); #1;
    plb.Bus2IP_Mst_Cmd_Timeout = 1'b0;
    plb.Bus2IP_Mst_CmdAck      = 1'b0;
    if (kind != 2) begin
      repeat (dat_lat) begin
        @(posedge PLB_clk); #1;
      end
      plb.Bus2IP_MstRd_src_rdy_n = 1'b0;
      plb.Bus2IP_MstRd_d         = d;
      if (same_cycle) begin
        plb.Bus2IP_Mst_Cmplt = 1'b1;
        plb.Bus2IP_Mst_Error = (kind == 1);
        if (stall) full_force = 1'b1;
      end
      @(posedge PLB_clk); #1;
      plb.Bus2IP_MstRd_src_rdy_n = 1'b1;
      plb.Bus2IP_MstRd_d         = $urandom;   // not valid, must not be latched
      if (!same_cycle) begin
        plb.Bus2IP_Mst_Cmplt = 1'b1;
        plb.Bus2IP_Mst_Error = (kind == 1);
        if (stall) full_force = 1'b1;
        @(posedge PLB_clk); #1;
      end
      plb.Bus2IP_Mst_Cmplt = 1'b0;
      plb.Bus2IP_Mst_Error = 1'b0;
    end
    push_exp((kind == 1 || kind == 2) ? 32'd0 : d);
    if (kind == 1 || kind == 2) err_exp++;
    if (stall) begin
      repeat (10) begin
        @(negedge PLB_clk);
        chk("stall_no_write", 32'(pix_wr_en), 32'd0);
        chk("stall_no_req", 32'(plb.IP2Bus_MstRd_Req), 32'd0);
      end
      @(posedge PLB_clk); #1;
      full_force = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    reset        = 1'b1;
    enable       = 1'b0;
    restart      = 1'b0;
    full_force   = 1'b0;
    full_rand    = 1'b0;
    full_rand_en = 1'b0;
    plb.Bus2IP_Mst_CmdAck      = 1'b0;
    plb.Bus2IP_Mst_Cmplt       = 1'b0;
    plb.Bus2IP_Mst_Error       = 1'b0;
    plb.Bus2IP_Mst_Rearbitrate = 1'b0;
    plb.Bus2IP_Mst_Cmd_Timeout = 1'b0;
    plb.Bus2IP_MstRd_d         = 32'h0;
    plb.Bus2IP_MstRd_src_rdy_n = 1'b1;
    plb.Bus2IP_MstWr_dst_rdy_n = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(posedge PLB_clk);
    #1 reset = 1'b0;
    @(posedge PLB_clk); #1;
    @(negedge PLB_clk);
    chk("rst_pix_data", pix_data, 32'd0);
    chk("rst_wr_en", 32'(pix_wr_en), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rd_req", 32'(plb.IP2Bus_MstRd_Req), 32'd0);
    chk("rst_wr_req", 32'(plb.IP2Bus_MstWr_Req), 32'd0);
    chk("rst_addr", plb.IP2Bus_Mst_Addr, 32'd0);
    chk("rst_be", 32'(plb.IP2Bus_Mst_BE), 32'hF);
    chk("rst_lock", 32'(plb.IP2Bus_Mst_Lock), 32'd0);
    chk("rst_mst_reset", 32'(plb.IP2Bus_Mst_Reset), 32'd0);
    chk("rst_wr_d", plb.IP2Bus_MstWr_d, 32'd0);
    mon_en = 1;

    // Straight scan over a frame wrap, data = {line, col}.
    @(posedge PLB_clk); #1 enable = 1'b1;
    for (int n = 0; n < 10; n++)
      serve(0, 32'((idx / Cols) << 16) | 32'(idx % Cols), 2, 1, 0, 0);
    // Rearbitrate once, then ack.
    serve(3, $urandom, 1, 1, 1, 0);
    // Error on Cmplt, then command timeout.
    serve(1, $urandom, 2, 0, 1, 0);
    serve(2, $urandom, 1, 0, 0, 0);
    drain();
    chk("err_count_directed", 32'(err_count), 32'(err_exp));
    // FIFO full across PUSH for 10 cycles.
    serve(0, $urandom, 1, 2, 0, 1);
    drain();

    // Random mix with random FIFO backpressure.
    full_rand_en = 1'b1;
    for (int n = 0; n < 40; n++)
      serve($urandom_range(0, 3), $urandom, $urandom_range(1, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 0);
    drain();
    full_rand_en = 1'b0;
    chk("err_count_random", 32'(err_count), 32'(err_exp));

    // Stop mid-frame, then restart from (0,0).
    if (idx == 0) serve(0, $urandom, 1, 0, 0, 0);
    serve(0, $urandom, 1, 0, 0, 0);
    enable = 1'b0;
    drain();
    repeat (4) @(negedge PLB_clk);
    chk("stopped_no_req", 32'(plb.IP2Bus_MstRd_Req), 32'd0);
    @(posedge PLB_clk); #1;
    restart = 1'b1;
    enable  = 1'b1;
    idx     = 0;
    @(posedge PLB_clk); #1 restart = 1'b0;
    serve(0, $urandom, 1, 1, 0, 0);
    serve(0, $urandom, 1, 1, 0, 0);
    drain();

    // Reset while in DATA; late Cmplt must be ignored.
    wait_req(ok);
    if (ok) begin
      @(posedge PLB_clk); #1 plb.Bus2IP_Mst_CmdAck = 1'b1;
      @(posedge PLB_clk); #1 plb.Bus2IP_Mst_CmdAck = 1'b0;
      reset  = 1'b1;
      enable = 1'b0;
      @(posedge PLB_clk); #1 reset = 1'b0;
      @(negedge PLB_clk);
      chk("rst_data_req", 32'(plb.IP2Bus_MstRd_Req), 32'd0);
      chk("rst_data_err", 32'(err_count), 32'd0);
      chk("rst_data_state", 32'(state), 32'd0);
      chk("rst_data_mst_reset", 32'(plb.IP2Bus_Mst_Reset), 32'd1);
      @(posedge PLB_clk); #1;
      plb.Bus2IP_Mst_Cmplt       = 1'b1;
      plb.Bus2IP_MstRd_src_rdy_n = 1'b0;
      plb.Bus2IP_MstRd_d         = 32'hDEAD_BEEF;
      @(posedge PLB_clk); #1;
      plb.Bus2IP_Mst_Cmplt       = 1'b0;
      plb.Bus2IP_MstRd_src_rdy_n = 1'b1;
      repeat (5) @(negedge PLB_clk);
      chk("late_cmplt_state", 32'(state), 32'd0);
      chk("late_cmplt_pixel", pix_data, 32'd0);
      idx     = 0;
      err_exp = 0;
      @(posedge PLB_clk); #1;
      enable  = 1'b1;
      restart = 1'b1;
      @(posedge PLB_clk); #1 restart = 1'b0;
      serve(0, $urandom, 2, 1, 0, 0);
      serve(0, $urandom, 2, 1, 0, 0);
      drain();
    end
    chk("err_count_final", 32'(err_count), 32'(err_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
